// File: rtl/uart_tx_ctrl_if.sv
// Transmit-side bundle between the byte source and the UART transmitter.
// The source (register file / FIFO read side) is the master; the
// transmitter is the slave and drives the serial line and busy flag back.
interface uart_tx_ctrl_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  DATA_VALID;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic [4:0]            prescale;
    logic                  TX_OUT;
    logic                  busy;

    modport master (
        output P_DATA, DATA_VALID, PAR_EN, PAR_TYP, prescale,
        input  TX_OUT, busy
    );

    modport slave (
        input  P_DATA, DATA_VALID, PAR_EN, PAR_TYP, prescale,
        output TX_OUT, busy
    );
endinterface

// File: rtl/uart_tx_ctrl.sv
// UART transmitter: one byte per accepted request, framed as
// start(0), DATA_WIDTH data bits LSB first, optional parity, stop(1).
// Every bit is held for the prescale value latched at acceptance
// (0 behaves as 1). TX_OUT and busy come straight from flops.
module uart_tx_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input  logic          CLK,
    input  logic          RST,
    uart_tx_ctrl_if.slave tx_if
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_e;

    localparam int                   BIT_CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BIT_CNT_W-1:0] LAST_BIT  = BIT_CNT_W'(DATA_WIDTH - 1);

    state_e                  state_q,    state_d;
    logic [4:0]              edge_cnt_q, edge_cnt_d;
    logic [BIT_CNT_W-1:0]    bit_cnt_q,  bit_cnt_d;
    logic [DATA_WIDTH-1:0]   data_q,     data_d;
    logic                    par_en_q,   par_en_d;
    logic                    par_typ_q,  par_typ_d;
    logic [4:0]              prescale_q, prescale_d;
    logic                    tx_out_q,   tx_out_d;
    logic                    busy_q,     busy_d;
    logic                    bit_end;

    // Last cycle of the current bit period; only meaningful outside IDLE,
    // where prescale_q is always at least 1.
    assign bit_end = (edge_cnt_q == prescale_q - 5'd1);

    // Next-state, counter and registered-output computation.
    always_comb begin
        // NOTE: every _d starts as a copy of its _q so that no path through
        // the case below leaves a signal unassigned and infers a latch.
        state_d    = state_q;
        edge_cnt_d = edge_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        data_d     = data_q;
        par_en_d   = par_en_q;
        par_typ_d  = par_typ_q;
        prescale_d = prescale_q;
        tx_out_d   = 1'b1;
        busy_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (tx_if.DATA_VALID) begin
                    data_d     = tx_if.P_DATA;
                    par_en_d   = tx_if.PAR_EN;
                    par_typ_d  = tx_if.PAR_TYP;
                    prescale_d = (tx_if.prescale == 5'd0) ? 5'd1 : tx_if.prescale;
                    edge_cnt_d = 5'd0;
                    bit_cnt_d  = '0;
                    state_d    = START;
                end
            end
            START: begin
                edge_cnt_d = bit_end ? 5'd0 : edge_cnt_q + 5'd1;
                if (bit_end) begin
                    bit_cnt_d = '0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                edge_cnt_d = bit_end ? 5'd0 : edge_cnt_q + 5'd1;
                if (bit_end) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
                        state_d   = par_en_q ? PARITY : STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                    end
                end
            end
            PARITY: begin
                edge_cnt_d = bit_end ? 5'd0 : edge_cnt_q + 5'd1;
                if (bit_end) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                edge_cnt_d = bit_end ? 5'd0 : edge_cnt_q + 5'd1;
                if (bit_end) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d    = IDLE;
                edge_cnt_d = 5'd0;
                bit_cnt_d  = '0;
            end
        endcase

        // Line level and busy are decoded from the next state so the flops
        // present them in the same cycle the FSM enters that state.
        case (state_d)
            START:   tx_out_d = 1'b0;
            DATA:    tx_out_d = data_d[bit_cnt_d];
            PARITY:  tx_out_d = (^data_d) ^ par_typ_d;
            default: tx_out_d = 1'b1;
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            // NOTE: the latched byte and configuration are reset along with the
            // control state; they are plain registers, not a memory array, and
            // a cleared value keeps the parity path defined after an abort.
            state_q    <= IDLE;
            edge_cnt_q <= 5'd0;
            bit_cnt_q  <= '0;
            data_q     <= '0;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            prescale_q <= 5'd0;
            tx_out_q   <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values computed above, independent of statement order.
            state_q    <= state_d;
            edge_cnt_q <= edge_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            data_q     <= data_d;
            par_en_q   <= par_en_d;
            par_typ_q  <= par_typ_d;
            prescale_q <= prescale_d;
            tx_out_q   <= tx_out_d;
            busy_q     <= busy_d;
        end
    end

    assign tx_if.TX_OUT = tx_out_q;
    assign tx_if.busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl. A line monitor pops the expected
// frame from a scoreboard queue at each start bit and checks every cycle
// of the frame, recovers the byte at mid-bit, and checks the idle cycle
// after the stop bit. A vector table supplies hand-derived frame lengths
// and parity bits; hand-written sequences cover the multi-cycle cases.
module tb_uart_tx_ctrl;

    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    uart_tx_ctrl_if #(.DATA_WIDTH(DW)) tx_if ();

    uart_tx_ctrl #(.DATA_WIDTH(DW)) dut (
        .CLK   (clk),
        .RST   (rst),
        .tx_if (tx_if.slave)
    );

    typedef struct {
        logic [7:0] data;
        logic       par_en;
        logic       par_typ;
        logic [4:0] prescale;
        int         exp_len;
        logic       exp_par;
    } vec_t;

    typedef struct {
        logic [7:0] data;
        logic       par_en;
        logic       par_bit;
        int         p;
    } frame_t;

    frame_t sb_q[$];
    int     n_cmp       = 0;
    int     n_err       = 0;
    int     frames_done = 0;
    int     exp_frames  = 0;
    bit     mon_en      = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic model_par(input logic [7:0] d, input logic pt);
        return (^d) ^ pt;
    endfunction

    task automatic push_frame(input logic [7:0] d, input logic pe, input logic [4:0] ps,
                              input logic pbit);
        frame_t f;
        f.data    = d;
        f.par_en  = pe;
        f.par_bit = pbit;
        f.p       = (ps == 5'd0) ? 1 : int'(ps);
        sb_q.push_back(f);
        exp_frames++;
    endtask

    // Drive one request for a single cycle; the acceptance edge is the
    // posedge after the first negedge. Checks the one-cycle latency.
    task automatic send(input logic [7:0] d, input logic pe, input logic pt,
                        input logic [4:0] ps, input bit push, input logic pbit);
        @(negedge clk);
        tx_if.P_DATA     = d;
        tx_if.PAR_EN     = pe;
        tx_if.PAR_TYP    = pt;
        tx_if.prescale   = ps;
        tx_if.DATA_VALID = 1'b1;
        if (push) push_frame(d, pe, ps, pbit);
        @(negedge clk);
        tx_if.DATA_VALID = 1'b0;
        check("accept_latency{busy,tx}", {tx_if.busy, tx_if.TX_OUT}, 2'b10);
    endtask

    // Called at the negedge right after acceptance (busy already seen once).
    task automatic measure_busy(input int exp_len);
        int cnt = 1;
        while (cnt < 2000) begin
            @(negedge clk);
            if (tx_if.busy !== 1'b1) break;
            cnt++;
        end
        check("busy_len", cnt, exp_len);
    endtask

    task automatic wait_frames(input int budget);
        int n = 0;
        while (frames_done < exp_frames && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("frames_done", frames_done, exp_frames);
    endtask

    // Line monitor and receiver model.
    initial begin : monitor
        frame_t     f;
        int         nbits;
        logic [10:0] bits;
        logic [7:0] rx;
        forever begin
            @(negedge clk);
            if (mon_en && tx_if.TX_OUT === 1'b0) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_start", {31'd0, tx_if.TX_OUT}, 32'd1);
                end else begin
                    f     = sb_q.pop_front();
                    nbits = f.par_en ? 11 : 10;
                    bits  = '1;
                    bits[0]   = 1'b0;
                    bits[8:1] = f.data;
                    if (f.par_en) bits[9] = f.par_bit;
                    rx = '0;
                    for (int b = 0; b < nbits; b++) begin
                        for (int c = 0; c < f.p; c++) begin
                            if (b != 0 || c != 0) @(negedge clk);
                            check("tx_bit", {31'd0, tx_if.TX_OUT}, {31'd0, bits[b]});
                            check("busy_in_frame", {31'd0, tx_if.busy}, 32'd1);
                            if (b >= 1 && b <= DW && c == f.p / 2) rx[b-1] = tx_if.TX_OUT;
                        end
                    end
                    check("rx_data", {24'd0, rx}, {24'd0, f.data});
                    @(negedge clk);
                    check("idle_after_frame{busy,tx}", {tx_if.busy, tx_if.TX_OUT}, 2'b01);
                    frames_done++;
                end
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        vec_t  vecs[8];
        int    accepted;
        int    cyc;
        logic [4:0] cfg_ps[3];
        logic [7:0] rd;

        //          data   pe    pt    ps     len  par
        vecs[0] = '{8'hA5, 1'b0, 1'b0, 5'd8,   80, 1'b0};
        vecs[1] = '{8'h37, 1'b1, 1'b0, 5'd16, 176, 1'b1};
        vecs[2] = '{8'h37, 1'b1, 1'b1, 5'd16, 176, 1'b0};
        vecs[3] = '{8'h00, 1'b1, 1'b0, 5'd3,   33, 1'b0};
        vecs[4] = '{8'hFF, 1'b1, 1'b1, 5'd5,   55, 1'b1};
        vecs[5] = '{8'h01, 1'b0, 1'b0, 5'd1,   10, 1'b0};
        vecs[6] = '{8'h80, 1'b1, 1'b0, 5'd0,   11, 1'b1};
        vecs[7] = '{8'h5A, 1'b1, 1'b1, 5'd31, 341, 1'b1};

        tx_if.P_DATA     = '0;
        tx_if.DATA_VALID = 1'b0;
        tx_if.PAR_EN     = 1'b0;
        tx_if.PAR_TYP    = 1'b0;
        tx_if.prescale   = 5'd0;
        rst              = 1'b1;

        // Reset state.
        @(negedge clk);
        check("reset_state_1{busy,tx}", {tx_if.busy, tx_if.TX_OUT}, 2'b01);
        @(negedge clk);
        check("reset_state_2{busy,tx}", {tx_if.busy, tx_if.TX_OUT}, 2'b01);
        rst    = 1'b0;
        mon_en = 1'b1;

        // Table-driven frames.
        for (int i = 0; i < 8; i++) begin
            send(vecs[i].data, vecs[i].par_en, vecs[i].par_typ, vecs[i].prescale,
                 1'b1, vecs[i].exp_par);
            measure_busy(vecs[i].exp_len);
            wait_frames(50);
        end

        // Busy protection: DATA_VALID held high, P_DATA churning every cycle.
        @(negedge clk);
        tx_if.PAR_EN     = 1'b0;
        tx_if.PAR_TYP    = 1'b0;
        tx_if.prescale   = 5'd4;
        tx_if.P_DATA     = 8'h3C;
        tx_if.DATA_VALID = 1'b1;
        push_frame(8'h3C, 1'b0, 5'd4, 1'b0);
        accepted = 1;
        cyc      = 0;
        while (accepted < 2 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            tx_if.P_DATA = 8'($urandom);
            if (tx_if.busy === 1'b0) begin
                push_frame(tx_if.P_DATA, 1'b0, 5'd4, 1'b0);
                accepted++;
            end
        end
        @(negedge clk);
        tx_if.DATA_VALID = 1'b0;
        check("busy_prot_accepts", accepted, 2);
        check("busy_prot_second_start{busy,tx}", {tx_if.busy, tx_if.TX_OUT}, 2'b10);
        wait_frames(200);

        // Configuration changes mid-frame have no effect; prescale 0 acts as 1.
        send(8'hC3, 1'b0, 1'b0, 5'd8, 1'b1, 1'b0);
        tx_if.prescale = 5'd31;
        tx_if.PAR_EN   = 1'b1;
        tx_if.PAR_TYP  = 1'b1;
        tx_if.P_DATA   = 8'h00;
        measure_busy(80);
        wait_frames(50);
        send(8'h96, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
        measure_busy(10);
        wait_frames(50);

        // Reset during DATA bit 3 aborts the frame.
        mon_en = 1'b0;
        send(8'h00, 1'b0, 1'b0, 5'd4, 1'b0, 1'b0);
        repeat (17) @(negedge clk);
        check("pre_reset_bit3{busy,tx}", {tx_if.busy, tx_if.TX_OUT}, 2'b10);
        rst = 1'b1;
        @(negedge clk);
        check("reset_abort_1{busy,tx}", {tx_if.busy, tx_if.TX_OUT}, 2'b01);
        @(negedge clk);
        check("reset_abort_2{busy,tx}", {tx_if.busy, tx_if.TX_OUT}, 2'b01);
        rst    = 1'b0;
        mon_en = 1'b1;
        send(8'h6E, 1'b1, 1'b0, 5'd2, 1'b1, model_par(8'h6E, 1'b0));
        measure_busy(22);
        wait_frames(50);

        // Loopback-style random traffic over prescale and parity settings.
        cfg_ps[0] = 5'd8;
        cfg_ps[1] = 5'd16;
        cfg_ps[2] = 5'd31;
        for (int p = 0; p < 3; p++) begin
            for (int m = 0; m < 3; m++) begin
                for (int k = 0; k < 4; k++) begin
                    rd = 8'($urandom);
                    send(rd, m != 0, m == 2, cfg_ps[p], 1'b1, model_par(rd, m == 2));
                    wait_frames(500);
                end
            end
        end

        check("scoreboard_empty", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
